spi_host_master: RTL and testbench
==================================

SPI_HOST_MASTER -- requirements
Module: spi_host_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4; clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter DATA_W, default 8; bits per SPI word.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_valid  input  1  host word available.
REQ-006 SHALL have port tx_data  input  DATA_W  word to transmit, MSB first.
REQ-007 SHALL have port tx_last  input  1  word closes the transaction; CS released afterwards.
REQ-008 SHALL have port tx_ready  output  1  word accepted when tx_valid and tx_ready are both high.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-010 SHALL have port rx_data  output  DATA_W  word sampled from MISO; held until the next rx_valid.
REQ-011 SHALL have port busy  output  1  high whenever cs_n is low or a trail/gap phase is active.
REQ-012 SHALL have ports SCLK, MOSI, CS (active-low chip select, cs_n semantics) as outputs and MISO as input, each 1 bit; these are the SNN slave's SPI pins.

Function
REQ-013 SHALL implement SPI mode 0: SCLK idles low; MOSI changes only while SCLK is low; MISO is sampled on each SCLK rising edge.
REQ-014 SHALL implement FSM states IDLE, LEAD, HIGH, LOW, BOUNDARY, TRAIL and GAP.
REQ-015 IDLE SHALL hold CS=1, SCLK=0 and tx_ready=1; on handshake it SHALL latch tx_data and tx_last, drive CS=0 and MOSI=tx_data[MSB] on the next cycle, and enter LEAD.
REQ-016 LEAD, HIGH, LOW, TRAIL and GAP SHALL each last exactly CLK_DIV clk cycles, timed by a half-period counter that reloads on every state change.
REQ-017 Exiting LEAD or LOW SHALL raise SCLK and sample MISO into the shift register LSB; exiting HIGH SHALL drop SCLK and, if bits remain, present the next MOSI bit.
REQ-018 After the DATA_W-th LOW phase, the FSM SHALL pulse rx_valid for one cycle with the full received word and enter BOUNDARY if the latched last flag is 0, or TRAIL if it is 1.
REQ-019 BOUNDARY SHALL hold CS=0, SCLK=0 and tx_ready=1 for an unbounded stall; a handshake there SHALL load the new word and continue directly with LEAD, without a CS glitch.
REQ-020 TRAIL SHALL keep CS=0; GAP SHALL drive CS=1; GAP SHALL return to IDLE, guaranteeing CS high for at least CLK_DIV cycles between transactions.
REQ-021 tx_ready SHALL be 0 in all states other than IDLE and BOUNDARY; tx_valid in other states SHALL be ignored and not lost; the host holds it.
REQ-022 Single-word transaction: CS SHALL stay low for exactly (DATA_W*2+2)*CLK_DIV cycles, i.e. 36 for DATA_W=8 and CLK_DIV=2.
REQ-023 Bit counter SHALL be ceil(log2(DATA_W+1)) bits wide and SHALL never wrap within a word.

Reset
REQ-024 Reset SHALL force IDLE, CS=1, SCLK=0, MOSI=0, tx_ready=0 for the reset cycle, rx_valid=0, rx_data=0, busy=0 and clear all counters.
REQ-025 Reset asserted mid-word SHALL release CS on the next clock edge, with no rx_valid pulse and no GAP phase.

Structure
REQ-026 Package snn_spi_pkg SHALL hold the FSM state enum, the SPI mode-0 constants, and the default CLK_DIV and DATA_W values.
REQ-027 The half-period counter and edge strobes SHALL be a sub-module, spi_sclk_gen, with outputs rise_stb, fall_stb and phase_done.

Verification
REQ-028 CLK_DIV=2, single 0xA5 with tx_last=1, MISO looped to MOSI -> rx_data=0xA5, one rx_valid pulse, CS low for 36 cycles, 8 SCLK rising edges.
REQ-029 Two words 0x3C then 0xC3 (last on the second), tx_valid held -> CS never rises between words; rx_data 0x3C then 0xC3; 16 rising edges.
REQ-030 Stall: tx_valid withheld 50 cycles in BOUNDARY -> CS stays 0, SCLK stays 0, no extra edges, and the next word completes correctly.
REQ-031 MISO forced to 1 while sending 0x00 -> rx_data=0xFF; MOSI stays 0 on every rising edge.
REQ-032 Reset asserted at the 4th rising edge -> CS=1 and SCLK=0 on the next clk, no rx_valid; a fresh 0x5A transaction afterwards passes.
REQ-033 Back-to-back single-word transactions -> CS high for at least 2 cycles between them; a checker confirms MOSI changes only while SCLK is low.

Source files
------------

// File: rtl/snn_spi_pkg.sv
// Shared definitions for the SPI host master: FSM states, SPI mode-0
// constants and the default timing/width parameters.
package snn_spi_pkg;

    localparam int DEFAULT_CLK_DIV = 4;
    localparam int DEFAULT_DATA_W  = 8;

    // Mode 0: clock idles low, data is captured on the leading (rising) edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_BOUNDARY,
        ST_TRAIL,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI host master. Counts CLK_DIV cycles while the
// FSM sits in a timed phase and emits phase_done on the last cycle; the rise
// and fall strobes qualify phase_done with the kind of phase being left.
module spi_sclk_gen
    import snn_spi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic rise_phase,
    input  logic fall_phase,
    output logic rise_stb,
    output logic fall_stb,
    output logic phase_done
);

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_reg;

    assign phase_done = run && (cnt_reg == CNT_LAST);
    assign rise_stb   = phase_done && rise_phase;
    assign fall_stb   = phase_done && fall_phase;

    // Every timed phase ends on phase_done, so wrapping to zero there is the
    // reload that gives the following phase its full CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset || !run || phase_done) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 host master. Accepts words over a valid/ready stream, shifts
// them out MSB first on MOSI while capturing MISO, and keeps CS low across
// words until a word flagged last has been sent.
module spi_host_master
    import snn_spi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS,
    input  logic              MISO
);

    localparam int              BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    state_t            state_reg;
    logic [DATA_W-1:0] tx_sh_reg;
    logic [DATA_W-1:0] rx_sh_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic              last_reg;
    logic              sclk_reg;
    logic              mosi_reg;
    logic              cs_reg;
    logic              tx_ready_reg;
    logic              rx_valid_reg;
    logic              busy_reg;

    logic timed;
    logic rise_phase;
    logic fall_phase;
    logic rise_stb;
    logic fall_stb;
    logic phase_done;
    logic handshake;

    // LEAD always ends with a rising edge; a LOW phase does so only while
    // samples are still outstanding, the final LOW closes the word instead.
    assign timed      = (state_reg == ST_LEAD) || (state_reg == ST_HIGH) ||
                        (state_reg == ST_LOW)  || (state_reg == ST_TRAIL) ||
                        (state_reg == ST_GAP);
    assign rise_phase = (state_reg == ST_LEAD) ||
                        ((state_reg == ST_LOW) && (bit_cnt_reg != BIT_LAST));
    assign fall_phase = (state_reg == ST_HIGH);
    assign handshake  = tx_valid && tx_ready_reg;

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (timed),
        .rise_phase(rise_phase),
        .fall_phase(fall_phase),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .phase_done(phase_done)
    );

    // Transaction FSM; every pin and handshake output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            rx_data_reg  <= '0;
            bit_cnt_reg  <= '0;
            last_reg     <= 1'b0;
            sclk_reg     <= SPI_CPOL;
            mosi_reg     <= 1'b0;
            cs_reg       <= 1'b1;
            tx_ready_reg <= 1'b0;
            rx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_BOUNDARY: begin
                    if (handshake) begin
                        tx_sh_reg    <= tx_data;
                        last_reg     <= tx_last;
                        mosi_reg     <= tx_data[DATA_W-1];
                        cs_reg       <= 1'b0;
                        bit_cnt_reg  <= '0;
                        tx_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_LEAD;
                    end else begin
                        tx_ready_reg <= 1'b1;
                    end
                end
                ST_LEAD, ST_LOW: begin
                    if (rise_stb) begin
                        sclk_reg    <= 1'b1;
                        rx_sh_reg   <= {rx_sh_reg[DATA_W-2:0], MISO};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        state_reg   <= ST_HIGH;
                    end else if (phase_done) begin
                        rx_valid_reg <= 1'b1;
                        rx_data_reg  <= rx_sh_reg;
                        if (last_reg) begin
                            state_reg <= ST_TRAIL;
                        end else begin
                            tx_ready_reg <= 1'b1;
                            state_reg    <= ST_BOUNDARY;
                        end
                    end
                end
                ST_HIGH: begin
                    if (fall_stb) begin
                        sclk_reg <= 1'b0;
                        if (bit_cnt_reg != BIT_LAST) begin
                            tx_sh_reg <= tx_sh_reg << 1;
                            mosi_reg  <= tx_sh_reg[DATA_W-2];
                        end
                        state_reg <= ST_LOW;
                    end
                end
                ST_TRAIL: begin
                    if (phase_done) begin
                        cs_reg    <= 1'b1;
                        mosi_reg  <= 1'b0;
                        state_reg <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (phase_done) begin
                        busy_reg     <= 1'b0;
                        tx_ready_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;
    assign busy     = busy_reg;
    assign SCLK     = sclk_reg;
    assign MOSI     = mosi_reg;
    assign CS       = cs_reg;

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: random word streams with three MISO sources
// (loopback, constant level, slave word), a scoreboard of expected MOSI and
// rx words, and a pin monitor for CS timing and mode-0 MOSI behaviour.
module tb_spi_host_master;

    localparam int CLK_DIV       = 2;
    localparam int DATA_W        = 8;
    localparam int CS_LOW_SINGLE = (2 * DATA_W + 2) * CLK_DIV;
    localparam int WORD_CYCLES   = (2 * DATA_W + 1) * CLK_DIV;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              tx_valid = 1'b0;
    logic              tx_last  = 1'b0;
    logic [DATA_W-1:0] tx_data  = '0;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              cs;
    logic              miso;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] slave_q[$];

    int         miso_mode   = 0;
    logic       miso_const  = 1'b0;
    logic [7:0] cur_sword   = '0;
    int         bit_i       = 0;
    bit         word_loaded = 1'b0;
    logic [7:0] mosi_word   = '0;

    int   rises       = 0;
    int   cs_rises    = 0;
    int   cs_low_cnt  = 0;
    int   cs_high_cnt = 0;
    int   last_cs_low = 0;
    int   busy_err    = 0;
    int   rx_seen     = 0;
    logic sclk_prev   = 1'b0;
    logic mosi_prev   = 1'b0;
    logic cs_prev     = 1'b1;

    logic [7:0] wd[4];
    logic [7:0] sw[4];

    always #5 clk = ~clk;

    assign miso = (miso_mode == 0) ? mosi :
                  (miso_mode == 1) ? miso_const :
                  cur_sword[3'(7 - bit_i)];

    spi_host_master #(
        .CLK_DIV(CLK_DIV),
        .DATA_W (DATA_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .busy    (busy),
        .SCLK    (sclk),
        .MOSI    (mosi),
        .CS      (cs),
        .MISO    (miso)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pin monitor and scoreboard, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (rx_valid) rx_seen++;
        if (reset) begin
            if (cs) cs_high_cnt++;
            sclk_prev = sclk;
            mosi_prev = mosi;
            cs_prev   = cs;
        end else begin
            if (rx_valid) begin
                if (exp_rx_q.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_data", int'(rx_data), int'(exp_rx_q.pop_front()));
            end
            if (mosi !== mosi_prev) check("mosi_changes_with_sclk_low", int'(sclk), 0);
            if (!word_loaded && slave_q.size() > 0) begin
                cur_sword   = slave_q.pop_front();
                word_loaded = 1'b1;
            end
            if (sclk && !sclk_prev) begin
                rises++;
                mosi_word = {mosi_word[6:0], mosi};
                bit_i++;
                if (bit_i == DATA_W) begin
                    bit_i       = 0;
                    word_loaded = 1'b0;
                    if (exp_tx_q.size() == 0) check("mosi_unexpected_word", 1, 0);
                    else check("mosi_word", int'(mosi_word), int'(exp_tx_q.pop_front()));
                end
            end
            if (!cs) begin
                if (cs_prev) check("cs_high_gap_min", int'(cs_high_cnt >= CLK_DIV), 1);
                cs_low_cnt++;
                if (!busy) busy_err++;
            end else begin
                if (!cs_prev) begin
                    last_cs_low = cs_low_cnt;
                    cs_low_cnt  = 0;
                    cs_high_cnt = 0;
                    cs_rises++;
                end
                cs_high_cnt++;
            end
            sclk_prev = sclk;
            mosi_prev = mosi;
            cs_prev   = cs;
        end
    end

    task automatic wait_ready(output bit ok);
        int t = 0;
        while (!tx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        ok = tx_ready;
        check("handshake_ready", int'(tx_ready), 1);
    endtask

    task automatic push_expect(input int w, input int nw);
        exp_tx_q.push_back(wd[w]);
        slave_q.push_back(sw[w]);
        if (miso_mode == 0)      exp_rx_q.push_back(wd[w]);
        else if (miso_mode == 1) exp_rx_q.push_back({8{miso_const}});
        else                     exp_rx_q.push_back(sw[w]);
        tx_data  = wd[w];
        tx_last  = (w == nw - 1);
        tx_valid = 1'b1;
    endtask

    // One CS-framed transaction of nw words; stall withholds tx_valid in BOUNDARY.
    task automatic run_txn(input int id, input int nw, input int stall);
        int r0, c0, b0, r, bad, t;
        bit ok;
        logic [7:0] exp_last;
        r0 = rises;
        c0 = cs_rises;
        b0 = busy_err;
        exp_last = '0;
        for (int w = 0; w < nw; w++) begin
            push_expect(w, nw);
            exp_last = (miso_mode == 0) ? wd[w] : (miso_mode == 1) ? {8{miso_const}} : sw[w];
            wait_ready(ok);
            if (!ok) begin
                tx_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (w == nw - 1) begin
                tx_valid = 1'b0;
            end else if (stall > 0) begin
                tx_valid = 1'b0;
                wait_ready(ok);
                if (!ok) return;
                r   = rises;
                bad = 0;
                repeat (stall) begin
                    @(negedge clk);
                    if (cs !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1) bad++;
                end
                check("stall_pins_held", bad, 0);
                check("stall_no_sclk_edges", rises - r, 0);
            end
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(cs && !busy && tx_ready) && t < 2000);
        check("txn_completes", int'(cs && !busy && tx_ready), 1);
        check("cs_single_release", cs_rises - c0, 1);
        check("sclk_rising_edges", rises - r0, DATA_W * nw);
        check("busy_while_cs_low", busy_err - b0, 0);
        check("rx_scoreboard_drained", exp_rx_q.size(), 0);
        check("rx_data_held", int'(rx_data), int'(exp_last));
        if (nw == 1) check("cs_low_cycles", last_cs_low, CS_LOW_SINGLE);
        else check("cs_low_min_cycles", int'(last_cs_low >= nw * WORD_CYCLES + CLK_DIV), 1);
        $display("txn %0d words=%0d mode=%0d stall=%0d cs_low=%0d rx_last=%02h",
                 id, nw, miso_mode, stall, last_cs_low, rx_data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int r0, rx0, t;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_cs", int'(cs), 1);
        check("reset_sclk", int'(sclk), 0);
        check("reset_mosi", int'(mosi), 0);
        check("reset_tx_ready", int'(tx_ready), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_tx_ready", int'(tx_ready), 1);
        check("idle_cs", int'(cs), 1);

        // Single 0xA5 with loopback.
        miso_mode = 0;
        wd[0] = 8'hA5; sw[0] = 8'h00;
        run_txn(0, 1, 0);

        // Two words held back to back.
        wd[0] = 8'h3C; wd[1] = 8'hC3; sw[0] = 8'h00; sw[1] = 8'h00;
        run_txn(1, 2, 0);

        // Long stall in BOUNDARY, slave supplies its own words.
        miso_mode = 2;
        wd[0] = 8'($urandom); wd[1] = 8'($urandom);
        sw[0] = 8'($urandom); sw[1] = 8'($urandom);
        run_txn(2, 2, 50);

        // MISO stuck high while sending zero.
        miso_mode = 1; miso_const = 1'b1;
        wd[0] = 8'h00; sw[0] = 8'h00;
        run_txn(3, 1, 0);

        // Reset at the 4th rising edge of a word.
        miso_mode = 0;
        wd[0] = 8'($urandom); sw[0] = 8'h00;
        r0 = rises;
        push_expect(0, 1);
        wait_ready(ok);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        t = 0;
        while (rises < r0 + 4 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reached_4th_edge", rises - r0, 4);
        reset = 1'b1;
        rx0 = rx_seen;
        @(posedge clk);
        #1;
        check("midword_reset_cs", int'(cs), 1);
        check("midword_reset_sclk", int'(sclk), 0);
        check("midword_reset_rx_data", int'(rx_data), 0);
        exp_rx_q.delete();
        exp_tx_q.delete();
        slave_q.delete();
        bit_i       = 0;
        word_loaded = 1'b0;
        cs_low_cnt  = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("midword_reset_no_rx", rx_seen - rx0, 0);
        wd[0] = 8'h5A; sw[0] = 8'h00;
        run_txn(4, 1, 0);

        // Randomised back-to-back transactions.
        for (int i = 0; i < 10; i++) begin
            int nw, st;
            nw = int'($urandom_range(1, 3));
            st = (($urandom & 1) != 0) ? int'($urandom_range(1, 5)) : 0;
            miso_mode  = int'($urandom_range(0, 2));
            miso_const = 1'($urandom);
            for (int w = 0; w < 4; w++) begin
                wd[w] = 8'($urandom);
                sw[w] = 8'($urandom);
            end
            run_txn(5 + i, nw, st);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
